// File: rtl/approx_eval_pkg.sv
// Shared types, defaults and helpers for the approximate-adder error monitor.
package approx_eval_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_FRAME_LEN = 10;

    // Working width of abs_diff; callers zero-extend in and truncate out.
    localparam int unsigned DIFF_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Unsigned absolute difference |x - y|.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] x,
                                                   input logic [DIFF_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_err_stage.sv
// Stage-1 register: exact sum and absolute error of one accepted sample.
module approx_err_stage
    import approx_eval_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OUT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OUT_W-1:0] o_approx,
    output logic             v1,
    output logic [OUT_W-1:0] abs_err
);

    logic [OUT_W-1:0] exact_c;

    assign exact_c = OUT_W'(a) + OUT_W'(b);

    // Capture the error of each accepted sample; v1 flags it for stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            abs_err <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                abs_err <= OUT_W'(abs_diff(DIFF_W'(o_approx), DIFF_W'(exact_c)));
            end
        end
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Frame-based error monitor for an approximate adder: counts FRAME_LEN
// accepted samples and accumulates error count, sum and max of |error|.
module approx_err_monitor
    import approx_eval_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned OUT_W     = WIDTH + 1,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int unsigned ACC_W     = OUT_W + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OUT_W-1:0] o_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [OUT_W-1:0] max_abs_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic             accept_c;
    logic             v1;
    logic [OUT_W-1:0] abs_err;

    assign accept_c = in_valid && in_ready;

    approx_err_stage #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept_c),
        .a        (a),
        .b        (b),
        .o_approx (o_approx),
        .v1       (v1),
        .abs_err  (abs_err)
    );

    // Frame control FSM with stage-2 accumulators; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_cnt  <= '0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else begin
            // Stage 2: fold the previous cycle's error into the frame totals.
            if (v1) begin
                err_count   <= err_count + CNT_W'(abs_err != '0);
                sum_abs_err <= sum_abs_err + ACC_W'(abs_err);
                if (abs_err > max_abs_err) begin
                    max_abs_err <= abs_err;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        sample_cnt  <= '0;
                        err_count   <= '0;
                        sum_abs_err <= '0;
                        max_abs_err <= '0;
                    end
                end
                S_RUN: begin
                    if (accept_c) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (sample_cnt == LAST_IDX) begin
                            state    <= S_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last sample is in stage 1 while v1 is high; once it
                    // clears, stage 2 has absorbed it.
                    if (!v1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
